lwir_line_compressor: RTL and testbench
=======================================

Name: lwir_line_compressor

Overview:
- Parametrised successor to the single-mode DPCM+RLE compression path for LWIR frames.
- Per-pixel predictor selectable at frame start: left, up, average, or MED (LOCO-I median). Uses an internal line buffer for the row above.
- Zero residuals are run-length coded; tokens leave through an output FIFO.
- Ready/valid backpressure on both sides. Sits between the sensor pixel stream and the packetiser.

Parameters:
PIX_W, 16, pixel width in bits; legal range 8..27
MAX_LINE, 640, maximum pixels per line (line-buffer depth)
MAX_RUN, 255, longest run per token; legal range 1..2^28-1
FIFO_DEPTH, 8, output FIFO entries; power of 2, >=8

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  pixel valid
in_ready  out  1  block accepts pixel
pixel_in  in  PIX_W  unsigned pixel
sof  in  1  first pixel of frame, qualified by in_valid&in_ready
eol  in  1  last pixel of line, qualified by in_valid&in_ready
mode  in  2  predictor select, sampled on the sof beat
out_valid  out  1  token valid
out_ready  in  1  downstream accepts token
token_out  out  32  coded token
line_ovf  out  1  sticky: line exceeded MAX_LINE

Behaviour:
- Reset (rst=0, asynchronous): in_ready=0, out_valid=0, token_out=0, line_ovf=0. Run count, column/row counters and FIFO are cleared; mode resets to 0. Line-buffer contents are don't-care (row 0 never reads them). Reset mid-frame discards all pending data; after release the block waits for the next sof, and pixels arriving before it are accepted and coded as row 0.
- Accept condition: beat = in_valid & in_ready. in_ready = 1 when FIFO free entries >= 4.
- Prediction is computed with left L and up U:
  - Mode 0: pred=L.
  - Mode 1: pred=U.
  - Mode 2: pred=floor((L+U)/2), with the sum computed PIX_W+1 wide.
  - Mode 3: MED with C=up-left: if C>=max(L,U) then min(L,U); if C<=min(L,U) then max(L,U); else L+U-C.
- Boundary rules, applied in this order:
  1. sof pixel: pred=0.
  2. Row 0: pred=L for all modes.
  3. Column 0 of row>0: pred=U for all modes.
- Residual: pixel-pred, signed, PIX_W+1 bits, exact (no wrap).
- Line buffer: the column counter increments per beat and is cleared on eol; the row counter increments on eol and is cleared on sof. Column >= MAX_LINE sets line_ovf, drops the buffer write, and forces U=0 for that column on the next row. line_ovf clears only on reset.
- Pipeline: stage 1 registers the residual, eol and row0 flags. Stage 2 is the RLE FSM. The FIFO is show-ahead, so token_out is valid while out_valid=1. Minimum latency from an accepted beat to out_valid is 2 cycles.
- RLE FSM, states IDLE and RUN:
  - Zero residual: IDLE->RUN with count=1; in RUN, count++. When count reaches MAX_RUN, emit a run token and go to IDLE.
  - Nonzero residual: in RUN, emit the run token then a literal token in the same cycle (2 FIFO writes), go to IDLE. In IDLE, emit a literal only.
  - eol: any pending run is flushed. The last token of the line carries eol=1, whether it is a run or a literal. If the eol residual is zero, the flushed run includes it.
  - At most 2 FIFO writes per cycle. The 4-free threshold covers stage 1 plus stage 2.
- Token format:
  - [31:30] type: 00 literal, 01 run; 10 and 11 are unused.
  - [29] eol.
  - [28:0] payload: for a literal, the residual sign-extended to 29 bits; for a run, the length zero-extended (range 1..MAX_RUN).
- Output handshake: token_out must hold stable while out_valid & !out_ready. A FIFO read and write in the same cycle are legal, including when the FIFO is full, as long as the read happens.

Optional Feature:
- LWIR_STATS_EN defined: adds 32-bit output ports lit_cnt and run_cnt. They count literal and run tokens written to the FIFO, clear on the sof beat and on reset, and saturate at 2^32-1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Mode 0, one line of 4 pixels 100,100,100,105 with sof on the first and eol on the last -> tokens: literal +100; run 2 with eol=0; literal +5 with eol=1.
- Mode 1, two 3-pixel lines, row0=10,20,30 and row1=12,20,30 -> row1 emits literal +2 (col0 uses U), then run 2 with eol=1.
- Mode 3, row0=50,60 and row1=55,X: L=55, U=60, C=50. C<=min so pred=60. X=58 -> literal -2 with eol=1.
- MAX_RUN=4, 10 equal pixels after the first, eol on the last -> literal, run 4, run 4, run 2 with eol=1.
- out_ready held 0 for 20 cycles under a continuous nonzero stream -> in_ready drops when free<4, no token is lost, token_out is stable, and order is preserved after release.
- Assert rst=0 mid-run, then restart with sof -> outputs are 0 immediately, no stale run token appears, and the first token is a literal equal to the sof pixel value.

Source files
------------

// File: rtl/lwir_line_compressor.sv
// rtl/lwir_line_compressor.sv - LWIR line compressor: selectable DPCM predictor, zero-run RLE, token FIFO (optional LWIR_STATS_EN token counters)
module lwir_line_compressor #(
    parameter int PIX_W      = 16,
    parameter int MAX_LINE   = 640,
    parameter int MAX_RUN    = 255,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             sof,
    input  logic             eol,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      token_out,
`ifdef LWIR_STATS_EN
    output logic [31:0]      lit_cnt,
    output logic [31:0]      run_cnt,
`endif
    output logic             line_ovf
);

    localparam int COL_W = $clog2(MAX_LINE + 1);
    localparam int AW    = $clog2(MAX_LINE);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int RW    = PIX_W + 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_LINE);
    localparam logic [27:0]      RUN_MAX = 28'(MAX_RUN);
    localparam logic [CW-1:0]    RDY_THR = CW'(FIFO_DEPTH - 4);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // Stage 0: prediction context
    logic             beat;
    logic [COL_W-1:0] col_q, col_eff, col_d;
    logic             row0_q, row0_eff;
    logic [1:0]       mode_q, mode_eff;
    logic [PIX_W-1:0] left_q, ul_q, up, pred, mx, mn, avg, med_lin;
    logic [RW-1:0]    lu_sum, resid;
    logic             col_in_range, ovf_q, rdy_en_q;
    logic [PIX_W-1:0] lbuf [MAX_LINE];

    // Stage 1 / stage 2
    logic             s1_valid_q, s1_eol_q, s1_zero;
    logic [RW-1:0]    s1_res_q;
    state_t           state_q, state_d;
    logic [27:0]      cnt_q, cnt_d, run_next;

    // Output FIFO
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    fcnt_q;
    logic [1:0]       wr_n;
    logic [31:0]      wr0, wr1;
    logic             rd;

    function automatic logic [31:0] lit_tok(input logic [RW-1:0] r, input logic e);
        return {2'b00, e, {(29 - RW){r[RW-1]}}, r};
    endfunction

    function automatic logic [31:0] run_tok(input logic [27:0] n, input logic e);
        return {2'b01, e, 1'b0, n};
    endfunction

    assign rd        = out_valid & out_ready;
    assign out_valid = (fcnt_q != '0);
    assign token_out = out_valid ? fifo_mem[rd_ptr_q] : 32'd0;
    assign in_ready  = rdy_en_q & (fcnt_q <= RDY_THR);
    assign line_ovf  = ovf_q;

    // Resolve the effective column/row/mode; a sof beat restarts the frame in place
    always_comb begin
        beat         = in_valid & in_ready;
        col_eff      = sof ? '0 : col_q;
        row0_eff     = sof | row0_q;
        mode_eff     = sof ? mode : mode_q;
        col_in_range = (col_eff < COL_MAX);
        up           = col_in_range ? lbuf[col_eff[AW-1:0]] : '0;
        col_d        = eol ? '0 : (col_in_range ? col_eff + 1'b1 : col_eff);
    end

    // Predictor and exact PIX_W+1 residual
    always_comb begin
        lu_sum  = {1'b0, left_q} + {1'b0, up};
        avg     = PIX_W'(lu_sum >> 1);
        med_lin = PIX_W'(lu_sum - {1'b0, ul_q});
        mx      = (left_q >= up) ? left_q : up;
        mn      = (left_q >= up) ? up : left_q;
        if (sof) begin
            pred = '0;
        end else if (row0_eff) begin
            pred = left_q;
        end else if (col_eff == '0) begin
            pred = up;
        end else begin
            case (mode_eff)
                2'd0:    pred = left_q;
                2'd1:    pred = up;
                2'd2:    pred = avg;
                default: pred = (ul_q >= mx) ? mn : ((ul_q <= mn) ? mx : med_lin);
            endcase
        end
        resid = {1'b0, pixel_in} - {1'b0, pred};
    end

    // Column/row tracking, neighbour registers and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q    <= '0;
            row0_q   <= 1'b1;
            mode_q   <= 2'd0;
            left_q   <= '0;
            ul_q     <= '0;
            ovf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (beat) begin
                col_q  <= col_d;
                row0_q <= row0_eff & ~eol;
                mode_q <= mode_eff;
                left_q <= pixel_in;
                ul_q   <= up;
                if (!col_in_range) ovf_q <= 1'b1;
            end
        end
    end

    // Line buffer holds the row above; out-of-range columns are never stored
    always_ff @(posedge clk) begin
        if (beat && col_in_range) lbuf[col_eff[AW-1:0]] <= pixel_in;
    end

    // Stage 1 pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_eol_q   <= 1'b0;
        end else begin
            s1_valid_q <= beat;
            if (beat) begin
                s1_res_q <= resid;
                s1_eol_q <= eol;
            end
        end
    end

    assign s1_zero  = (s1_res_q == '0);
    assign run_next = (state_q == ST_RUN) ? cnt_q + 28'd1 : 28'd1;

    // RLE state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RLE next state: runs close on eol, on reaching MAX_RUN, or on a nonzero residual
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (s1_valid_q) begin
            if (s1_zero && !s1_eol_q && run_next != RUN_MAX) begin
                state_d = ST_RUN;
                cnt_d   = run_next;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    // RLE outputs: up to two FIFO writes, run token ahead of the literal
    always_comb begin
        wr_n = 2'd0;
        wr0  = 32'd0;
        wr1  = 32'd0;
        if (s1_valid_q) begin
            if (s1_zero) begin
                if (s1_eol_q || run_next == RUN_MAX) begin
                    wr_n = 2'd1;
                    wr0  = run_tok(run_next, s1_eol_q);
                end
            end else if (state_q == ST_RUN) begin
                wr_n = 2'd2;
                wr0  = run_tok(cnt_q, 1'b0);
                wr1  = lit_tok(s1_res_q, s1_eol_q);
            end else begin
                wr_n = 2'd1;
                wr0  = lit_tok(s1_res_q, s1_eol_q);
            end
        end
    end

    // FIFO storage (show-ahead read at rd_ptr_q)
    always_ff @(posedge clk) begin
        if (wr_n != 2'd0) fifo_mem[wr_ptr_q] <= wr0;
        if (wr_n == 2'd2) fifo_mem[wr_ptr_q + PW'(1)] <= wr1;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(wr_n);
            rd_ptr_q <= rd_ptr_q + PW'(rd);
            fcnt_q   <= fcnt_q + CW'(wr_n) - CW'(rd);
        end
    end

`ifdef LWIR_STATS_EN
    logic lit_inc, run_inc;
    assign lit_inc = (wr_n == 2'd2) || (wr_n == 2'd1 && wr0[31:30] == 2'b00);
    assign run_inc = (wr_n == 2'd2) || (wr_n == 2'd1 && wr0[31:30] == 2'b01);

    // Saturating token counters, restarted by each sof beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lit_cnt <= '0;
            run_cnt <= '0;
        end else if (beat && sof) begin
            lit_cnt <= '0;
            run_cnt <= '0;
        end else begin
            if (lit_inc && lit_cnt != 32'hFFFF_FFFF) lit_cnt <= lit_cnt + 32'd1;
            if (run_inc && run_cnt != 32'hFFFF_FFFF) run_cnt <= run_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lwir_line_compressor.sv
// tb/tb_lwir_line_compressor.sv - self-checking bench for lwir_line_compressor
module tb_lwir_line_compressor;

    localparam int ML = 8;
    localparam int MR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pixel_in = '0;
    logic        sof = 1'b0;
    logic        eol = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] token_out;
    logic        line_ovf;

    always #5 clk = ~clk;

    lwir_line_compressor #(
        .PIX_W(16), .MAX_LINE(ML), .MAX_RUN(MR), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_in(pixel_in), .sof(sof), .eol(eol), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .token_out(token_out),
        .line_ovf(line_ovf)
    );

    typedef struct packed {
        logic [15:0] px;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } beat_t;

    beat_t       pend[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          use_model = 0, rand_ready = 0, rand_valid = 0, hold_ready = 0;
    bit          saw_not_ready = 0, stall_prev = 0;
    logic [31:0] held_tok = '0;

    int above[ML];
    int cur[ML];
    int mrow = 0, mcol = 0, mmode = 0, mleft = 0, mrun = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tok_lit(input int r, input bit e);
        return {2'b00, e, r[28:0]};
    endfunction

    function automatic logic [31:0] tok_run(input int n, input bit e);
        return {2'b01, e, n[28:0]};
    endfunction

    task automatic push(input int px, input bit s, input bit e, input int m);
        beat_t b;
        b.px = px[15:0];
        b.s  = s;
        b.e  = e;
        b.m  = m[1:0];
        pend.push_back(b);
    endtask

    // Reference: prediction rules on whole-row arrays, then RLE on the residual stream
    task automatic model_step(input beat_t b);
        int l, u, c, pred, res, mx, mn;
        if (b.s) begin
            mrow = 0;
            mcol = 0;
            mmode = int'(b.m);
        end
        l = mleft;
        u = (mcol < ML) ? above[mcol] : 0;
        c = (mcol >= 1 && mcol - 1 < ML) ? above[mcol-1] : 0;
        if (b.s) pred = 0;
        else if (mrow == 0) pred = l;
        else if (mcol == 0) pred = u;
        else begin
            case (mmode)
                0: pred = l;
                1: pred = u;
                2: pred = (l + u) / 2;
                default: begin
                    mx = (l > u) ? l : u;
                    mn = (l > u) ? u : l;
                    if (c >= mx) pred = mn;
                    else if (c <= mn) pred = mx;
                    else pred = l + u - c;
                end
            endcase
        end
        res = int'(b.px) - pred;
        if (mcol < ML) cur[mcol] = int'(b.px);
        mleft = int'(b.px);
        if (res == 0) begin
            mrun++;
            if (b.e || mrun == MR) begin
                exp_q.push_back(tok_run(mrun, b.e));
                mrun = 0;
            end
        end else begin
            if (mrun > 0) exp_q.push_back(tok_run(mrun, 1'b0));
            exp_q.push_back(tok_lit(res, b.e));
            mrun = 0;
        end
        if (b.e) begin
            for (int i = 0; i < ML; i++) above[i] = cur[i];
            mrow++;
            mcol = 0;
        end else begin
            mcol++;
        end
    endtask

    // One clock: check/consume output, then present the next pending beat
    task automatic cyc();
        logic [31:0] e;
        beat_t b;
        @(negedge clk);
        if (stall_prev) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_token", token_out, held_tok);
        end
        if (hold_ready) out_ready = 1'b0;
        else out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            chk("token", token_out, e);
        end
        stall_prev = out_valid && !out_ready;
        held_tok   = token_out;
        if (!in_ready) saw_not_ready = 1'b1;
        if (pend.size() > 0 && !(rand_valid && $urandom_range(0, 3) == 0)) begin
            b = pend[0];
            in_valid = 1'b1;
            pixel_in = b.px;
            sof = b.s;
            eol = b.e;
            mode = b.m;
            if (in_ready) begin
                void'(pend.pop_front());
                if (use_model) model_step(b);
            end
        end else begin
            in_valid = 1'b0;
            sof = 1'b0;
            eol = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < 4000) begin
            cyc();
            n++;
        end
        if (n >= 4000) chk("drain_timeout", exp_q.size(), 32'd0);
        repeat (6) cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int px, w, rows, m, k, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_token", token_out, 32'd0);
        chk("rst_line_ovf", {31'd0, line_ovf}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Latency: single sof+eol beat, token visible two cycles after the beat
        in_valid = 1'b1; sof = 1'b1; eol = 1'b1; pixel_in = 16'd42; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; sof = 1'b0; eol = 1'b0;
        chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
        chk("lat_token", token_out, tok_lit(42, 1'b1));
        @(negedge clk);
        chk("lat_popped", {31'd0, out_valid}, 32'd0);

        // Mode 0: 100,100,100,105
        push(100, 1, 0, 0); push(100, 0, 0, 0); push(100, 0, 0, 0); push(105, 0, 1, 0);
        exp_q.push_back(tok_lit(100, 0)); exp_q.push_back(tok_run(2, 0)); exp_q.push_back(tok_lit(5, 1));
        drain();

        // Mode 1: row0 10,20,30; row1 12,20,30
        push(10, 1, 0, 1); push(20, 0, 0, 1); push(30, 0, 1, 1);
        push(12, 0, 0, 1); push(20, 0, 0, 1); push(30, 0, 1, 1);
        exp_q.push_back(tok_lit(10, 0)); exp_q.push_back(tok_lit(10, 0)); exp_q.push_back(tok_lit(10, 1));
        exp_q.push_back(tok_lit(2, 0)); exp_q.push_back(tok_run(2, 1));
        drain();

        // Mode 3 MED: row0 50,60; row1 55,58
        push(50, 1, 0, 3); push(60, 0, 1, 3); push(55, 0, 0, 3); push(58, 0, 1, 3);
        exp_q.push_back(tok_lit(50, 0)); exp_q.push_back(tok_lit(10, 1));
        exp_q.push_back(tok_lit(5, 0)); exp_q.push_back(tok_lit(-2, 1));
        drain();
        chk("ovf_before_long_line", {31'd0, line_ovf}, 32'd0);

        // MAX_RUN splitting over an 11-pixel line (also overruns MAX_LINE=8)
        push(7, 1, 0, 0);
        for (int i = 0; i < 10; i++) push(7, 0, i == 9, 0);
        exp_q.push_back(tok_lit(7, 0)); exp_q.push_back(tok_run(4, 0));
        exp_q.push_back(tok_run(4, 0)); exp_q.push_back(tok_run(2, 1));
        drain();
        chk("ovf_after_long_line", {31'd0, line_ovf}, 32'd1);

        // Backpressure: downstream stalled 20 cycles under a nonzero stream
        use_model = 1;
        hold_ready = 1;
        saw_not_ready = 0;
        for (int i = 0; i < 18; i++) push(1000 + 7 * i, i == 0, (i % 6) == 5, 0);
        repeat (20) cyc();
        chk("in_ready_dropped", {31'd0, saw_not_ready}, 32'd1);
        hold_ready = 0;
        drain();
        use_model = 0;

        // Reset in the middle of a pending run
        push(5, 1, 0, 0); push(5, 0, 0, 0); push(5, 0, 0, 0); push(5, 0, 0, 0);
        exp_q.push_back(tok_lit(5, 0));
        n = 0;
        while (pend.size() > 0 && n < 100) begin cyc(); n++; end
        repeat (2) cyc();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_token", token_out, 32'd0);
        chk("mid_rst_line_ovf", {31'd0, line_ovf}, 32'd0);
        exp_q.delete();
        pend.delete();
        stall_prev = 0;
        in_valid = 1'b0; sof = 1'b0; eol = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(123, 1, 0, 0); push(123, 0, 0, 0); push(200, 0, 1, 0);
        exp_q.push_back(tok_lit(123, 0)); exp_q.push_back(tok_run(1, 0)); exp_q.push_back(tok_lit(77, 1));
        drain();

        // Randomised frames against the reference model, with random stalls on both sides
        use_model = 1;
        rand_ready = 1;
        rand_valid = 1;
        for (int f = 0; f < 10; f++) begin
            m = $urandom_range(0, 3);
            w = $urandom_range(1, 10);
            rows = $urandom_range(1, 4);
            px = $urandom_range(0, 65535);
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < w; c++) begin
                    k = $urandom_range(0, 9);
                    if (k >= 8) px = $urandom_range(0, 65535);
                    else if (k >= 4) px = $urandom_range(100, 103);
                    push(px, r == 0 && c == 0, c == w - 1, m);
                end
            end
        end
        drain();
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
